bit_clmul_ctrl: RTL

BIT_CLMUL_CTRL -- requirements
Module: bit_clmul_ctrl

---
 rtl/bit_clmul_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bit_clmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_clmul_ctrl
// Brief    : Execute-stage sequencer for an iterative carry-less multiply core.
//            Optional macro BIT_CLMUL_CACHE_EN adds a one-entry result cache.
// Revision : 1.0 - initial release
// ============================================================================
module bit_clmul_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rdata1,
    input  logic [31:0] req_rdata2,
    input  logic [4:0]  req_waddr,
    input  logic        flush,
    output logic        core_enable,
    output logic [2:0]  core_op,
    output logic [31:0] core_rdata1,
    output logic [31:0] core_rdata2,
    input  logic [31:0] core_result,
    input  logic        core_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_waddr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_rdata1;
    logic [31:0] r_rdata2;
    logic [4:0]  r_waddr;
    logic [31:0] r_result;

    logic        w_op_onehot;
    logic        w_accept;
    logic        w_cache_hit;
    logic [31:0] w_cache_result;
    logic        w_core_enable;
    logic        w_stall;
    logic        w_resp_valid;

    assign w_op_onehot = (req_op != 3'b000) && ((req_op & (req_op - 3'd1)) == 3'b000);
    // Gated by rst so stall stays low while reset is held.
    assign w_accept    = rst && (r_state == S_IDLE) && req_valid && !flush && w_op_onehot;

`ifdef BIT_CLMUL_CACHE_EN
    logic        r_cache_valid;
    logic [2:0]  r_cache_op;
    logic [31:0] r_cache_rdata1;
    logic [31:0] r_cache_rdata2;
    logic [31:0] r_cache_result;

    assign w_cache_hit    = r_cache_valid && (r_cache_op == req_op) &&
                            (r_cache_rdata1 == req_rdata1) && (r_cache_rdata2 == req_rdata2);
    assign w_cache_result = r_cache_result;

    // Flush does not invalidate: the entry always holds a genuinely computed result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cache_valid  <= 1'b0;
            r_cache_op     <= 3'b000;
            r_cache_rdata1 <= 32'd0;
            r_cache_rdata2 <= 32'd0;
            r_cache_result <= 32'd0;
        end else if (r_state == S_DONE) begin
            r_cache_valid  <= 1'b1;
            r_cache_op     <= r_op;
            r_cache_rdata1 <= r_rdata1;
            r_cache_rdata2 <= r_rdata2;
            r_cache_result <= r_result;
        end
    end
`else
    assign w_cache_hit    = 1'b0;
    assign w_cache_result = 32'd0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_core_enable = 1'b0;
        w_stall       = 1'b0;
        w_resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_cache_hit ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_core_enable = 1'b1;
                    w_state_nxt   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (core_ready) begin
                    w_state_nxt = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    // The core cannot be aborted; its completion must still be absorbed.
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_resp_valid = !flush;
                w_state_nxt  = S_IDLE;
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                if (core_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= 3'b000;
            r_rdata1 <= 32'd0;
            r_rdata2 <= 32'd0;
            r_waddr  <= 5'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op     <= req_op;
                r_rdata1 <= req_rdata1;
                r_rdata2 <= req_rdata2;
                r_waddr  <= req_waddr;
                if (w_cache_hit) begin
                    r_result <= w_cache_result;
                end
            end
            if ((r_state == S_WAIT) && core_ready && !flush) begin
                r_result <= core_result;
            end
        end
    end

    assign core_enable = w_core_enable;
    assign core_op     = r_op;
    assign core_rdata1 = r_rdata1;
    assign core_rdata2 = r_rdata2;
    assign stall       = w_stall;
    assign resp_valid  = w_resp_valid;
    assign resp_result = r_result;
    assign resp_waddr  = r_waddr;

endmodule
`default_nettype wire
